// File: rtl/multi_cycle_control_unit.sv
// Control FSM for the multi-cycle MIPS-subset CPU.
// Moves each instruction through IF/ID/EXE/MEM/WB. Every datapath control
// line is decoded combinationally from the registered state, the current
// opcode and the ALU flags. Because the outputs depend on the state register,
// asserting Reset forces the FSM back to IF at once, so any pending write is
// dropped immediately.
module multi_cycle_control_unit #(
    parameter int OP_W = 6,
    parameter int ST_W = 3
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    output logic            PCWre,
    output logic            InsMemRW,
    output logic            IRWre,
    output logic            ExtSel,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic [2:0]      ALUOp,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic [1:0]      PCSrc,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR    = 6'b010000;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;

    state_t cur_state, nxt_state;

    // ALU-group decode, shared by EXE_AL and WB_AL (WB_AL holds the EXE lines)
    logic       is_alu, is_imm, alu_a, alu_b, alu_ext;
    logic [2:0] alu_op;
    logic       br_taken;

    assign state = cur_state;

    // State register; Reset low returns to IF asynchronously
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) cur_state <= S_IF;
        else        cur_state <= nxt_state;
    end

    // Decode ALU-class opcodes into operation and operand selects
    always_comb begin
        is_alu  = 1'b0;
        is_imm  = 1'b0;
        alu_op  = 3'b000;
        alu_a   = 1'b0;
        alu_b   = 1'b0;
        alu_ext = 1'b1;
        case (opcode)
            OP_ADD:   begin is_alu = 1'b1; alu_op = 3'b000; end
            OP_SUB:   begin is_alu = 1'b1; alu_op = 3'b001; end
            OP_ADDI:  begin is_alu = 1'b1; is_imm = 1'b1; alu_b = 1'b1; alu_op = 3'b000; end
            OP_OR:    begin is_alu = 1'b1; alu_op = 3'b011; end
            OP_AND:   begin is_alu = 1'b1; alu_op = 3'b100; end
            OP_ORI:   begin is_alu = 1'b1; is_imm = 1'b1; alu_b = 1'b1; alu_op = 3'b011; alu_ext = 1'b0; end
            OP_SLL:   begin is_alu = 1'b1; alu_a = 1'b1; alu_op = 3'b010; end
            OP_SLT:   begin is_alu = 1'b1; alu_op = 3'b110; end
            OP_SLTIU: begin is_alu = 1'b1; is_imm = 1'b1; alu_b = 1'b1; alu_op = 3'b101; end
            default:  ;
        endcase
    end

    // Branch decision; bltz tests the sign of rs - $0
    assign br_taken = ((opcode == OP_BEQ)  &  zero) |
                      ((opcode == OP_BNE)  & ~zero) |
                      ((opcode == OP_BLTZ) &  sign);

    // Next-state and control-line generation; every line defaults to 0
    always_comb begin
        nxt_state = cur_state;
        PCWre     = 1'b0;
        InsMemRW  = 1'b0;
        IRWre     = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;
        case (cur_state)
            S_IF: begin
                nxt_state = S_ID;
                InsMemRW  = 1'b1;
                IRWre     = 1'b1;
            end
            S_ID: begin
                if (is_alu) begin
                    nxt_state = S_EXE_AL;
                end else begin
                    case (opcode)
                        OP_BEQ, OP_BNE, OP_BLTZ: nxt_state = S_EXE_BR;
                        OP_SW, OP_LW:            nxt_state = S_EXE_LS;
                        OP_J: begin
                            nxt_state = S_IF;
                            PCSrc     = 2'b11;
                            PCWre     = 1'b1;
                        end
                        OP_JR: begin
                            nxt_state = S_IF;
                            PCSrc     = 2'b10;
                            PCWre     = 1'b1;
                        end
                        OP_JAL: begin
                            nxt_state = S_IF;
                            PCSrc     = 2'b11;
                            PCWre     = 1'b1;
                            RegWre    = 1'b1;
                            RegDst    = 2'b00;
                            WrRegDSrc = 1'b0;
                        end
                        // halt and undefined opcodes park here until Reset
                        default: nxt_state = S_ID;
                    endcase
                end
            end
            S_EXE_AL: begin
                nxt_state = S_WB_AL;
                if (is_alu) begin
                    ALUOp   = alu_op;
                    ALUSrcA = alu_a;
                    ALUSrcB = alu_b;
                    ExtSel  = alu_ext;
                end
            end
            S_WB_AL: begin
                nxt_state = S_IF;
                if (is_alu) begin
                    ALUOp   = alu_op;
                    ALUSrcA = alu_a;
                    ALUSrcB = alu_b;
                    ExtSel  = alu_ext;
                end
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b0;
                PCWre     = 1'b1;
                PCSrc     = 2'b00;
                RegDst    = is_imm ? 2'b01 : 2'b10;
            end
            S_EXE_BR: begin
                nxt_state = S_IF;
                ALUOp     = 3'b001;
                ExtSel    = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = br_taken ? 2'b01 : 2'b00;
            end
            S_EXE_LS: begin
                nxt_state = S_MEM;
                ALUOp     = 3'b000;
                ALUSrcB   = 1'b1;
                ExtSel    = 1'b1;
            end
            S_MEM: begin
                ALUOp   = 3'b000;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (opcode == OP_LW) begin
                    nxt_state = S_WB_LD;
                    mRD       = 1'b1;
                end else begin
                    nxt_state = S_IF;
                    if (opcode == OP_SW) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                        PCSrc = 2'b00;
                    end
                end
            end
            S_WB_LD: begin
                nxt_state = S_IF;
                mRD       = 1'b1;
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = 2'b01;
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = 2'b00;
            end
            default: nxt_state = S_IF;
        endcase
    end

endmodule
